// File: rtl/bus_ram_responder_if.sv
// Data-side memory bus between a CPU initiator and a RAM target.
// One transaction at a time on the request/ready handshake.
interface bus_ram_responder_if;
  logic        i_request;
  logic        i_rw;
  logic [31:0] i_address;
  logic [31:0] i_wdata;
  logic        o_ready;
  logic [31:0] o_rdata;
  logic        o_busy;

  modport master (
    output i_request, i_rw, i_address, i_wdata,
    input  o_ready, o_rdata, o_busy
  );

  modport slave (
    input  i_request, i_rw, i_address, i_wdata,
    output o_ready, o_rdata, o_busy
  );
endinterface

// File: rtl/bus_ram_responder.sv
// Word-wide scratch RAM answering the data bus after WAIT_STATES wait cycles.
// Transaction fields are captured on acceptance; the bus is ignored until IDLE again.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for i_request; latches rw/address/wdata on accept
// ST_WAIT   | burning programmed wait states (counter down to 1)
// ST_ACCESS | RAM write commit, or RAM read registered into o_rdata
// ST_READY  | one-cycle o_ready pulse, request ignored
module bus_ram_responder #(
  parameter int ADDR_BITS   = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic                i_clock,
  input  logic                i_reset,
  bus_ram_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_READY
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_t                 state;
  state_t                 state_nx;
  logic [3:0]             wait_cnt;
  logic                   lat_rw;
  logic [ADDR_BITS-1:0]   lat_addr;
  logic [31:0]            lat_wdata;
  logic [31:0]            rdata_q;
  logic [31:0]            mem [2**ADDR_BITS];
  logic                   accept;
  logic                   unused_addr;

  // Byte lane bits and bits above the RAM window alias onto the same word.
  assign unused_addr = ^{bus.i_address[31:ADDR_BITS+2], bus.i_address[1:0]};
  assign accept      = (state == ST_IDLE) && bus.i_request;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (bus.i_request) begin
          state_nx = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 4'd1) begin
          state_nx = ST_ACCESS;
        end
      end
      ST_ACCESS: state_nx = ST_READY;
      ST_READY:  state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Outputs decode only the state register, so nothing on the bus reaches them combinationally.
  always_comb begin
    bus.o_ready = 1'b0;
    bus.o_busy  = 1'b0;
    bus.o_rdata = rdata_q;
    if (state == ST_READY) begin
      bus.o_ready = 1'b1;
    end
    if (state != ST_IDLE) begin
      bus.o_busy = 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      wait_cnt  <= 4'd0;
      lat_rw    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= 32'd0;
      rdata_q   <= 32'd0;
    end else begin
      if (accept) begin
        lat_rw    <= bus.i_rw;
        lat_addr  <= bus.i_address[ADDR_BITS+1:2];
        lat_wdata <= bus.i_wdata;
        wait_cnt  <= WAIT_INIT;
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if ((state == ST_ACCESS) && !lat_rw) begin
        rdata_q <= mem[lat_addr];
      end
    end
  end

  // RAM has no reset; a write landing on a reset edge is dropped.
  always_ff @(posedge i_clock) begin
    if (i_reset && (state == ST_ACCESS) && lat_rw) begin
      mem[lat_addr] <= lat_wdata;
    end
  end

endmodule

// File: tb/tb_bus_ram_responder.sv
// Scoreboard bench: four responders with WAIT_STATES 0..3 share one clock.
// Expected completions are queued when a request is driven and popped on o_ready.
module tb_bus_ram_responder;

  logic        clk;
  logic        rst_n [4];
  logic        req   [4];
  logic        rw    [4];
  logic [31:0] addr  [4];
  logic [31:0] wd    [4];
  logic        rdy   [4];
  logic        bsy   [4];
  logic [31:0] rd    [4];

  int cyc;
  int last_ready [4];
  int n_cmp;
  int n_err;

  typedef struct {
    int          k;
    int          cyc;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  exp_t sbq [$];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    bus_ram_responder_if bus ();
    assign bus.i_request = req[g];
    assign bus.i_rw      = rw[g];
    assign bus.i_address = addr[g];
    assign bus.i_wdata   = wd[g];
    assign rdy[g]        = bus.o_ready;
    assign bsy[g]        = bus.o_busy;
    assign rd[g]         = bus.o_rdata;

    bus_ram_responder #(
      .ADDR_BITS   (12),
      .WAIT_STATES (g)
    ) dut (
      .i_clock (clk),
      .i_reset (rst_n[g]),
      .bus     (bus.slave)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      if (rdy[k] === 1'b1) begin
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
        end else begin
          e = '{k: -1, cyc: -1, rd: 1'b0, data: 32'd0};
        end
        chk("rdy_dut", 32'(k), 32'(e.k));
        chk("rdy_cyc", 32'(cyc), 32'(e.cyc));
        chk("busy_at_rdy", {31'd0, bsy[k]}, 32'd1);
        if (e.rd) chk("rdata", rd[k], e.data);
        last_ready[k] = cyc;
      end
    end
  end

  // Drive one transaction on responder k (WAIT_STATES == k) and queue its completion.
  task automatic txn(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp, input bit keep);
    int   acc;
    int   rdy_c;
    int   n;
    exp_t e;
    acc   = (cyc + 1 > last_ready[k] + 2) ? cyc + 1 : last_ready[k] + 2;
    rdy_c = acc + 1 + k;
    req[k]  = 1'b1;
    rw[k]   = w;
    addr[k] = a;
    wd[k]   = d;
    e.k = k; e.cyc = rdy_c; e.rd = !w; e.data = exp;
    sbq.push_back(e);
    while (cyc < acc) begin
      @(negedge clk); #1;
    end
    chk("busy_after_acc", {31'd0, bsy[k]}, 32'd1);
    if (!keep) begin
      req[k]  = 1'b0;
      rw[k]   = ~w;
      addr[k] = $urandom;
      wd[k]   = $urandom;
    end
    n = 0;
    while (last_ready[k] < rdy_c && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    if (last_ready[k] != rdy_c) chk("rdy_timeout", 32'(last_ready[k]), 32'(rdy_c));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    cyc   = 0;
    n_cmp = 0;
    n_err = 0;
    for (int k = 0; k < 4; k++) begin
      rst_n[k] = 1'b0;
      req[k]   = 1'b0;
      rw[k]    = 1'b0;
      addr[k]  = 32'd0;
      wd[k]    = 32'd0;
      last_ready[k] = -100;
    end

    // Reset held with a pending write on the W=1 responder.
    req[1] = 1'b1; rw[1] = 1'b1; addr[1] = 32'h10; wd[1] = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("rst_ready", {31'd0, rdy[1]}, 32'd0);
      chk("rst_busy",  {31'd0, bsy[1]}, 32'd0);
      chk("rst_rdata", rd[1], 32'd0);
    end
    for (int k = 0; k < 4; k++) rst_n[k] = 1'b1;

    // W=1 write/read; the write is accepted on the first edge after release.
    txn(1, 1'b1, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
    txn(1, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);

    // Aliasing: 0x4004 lands on word 1, as do 0x4 and 0x7.
    txn(1, 1'b1, 32'h0000_4004, 32'h1234_5678, 32'd0, 1'b0);
    txn(1, 1'b0, 32'h0000_0004, 32'd0, 32'h1234_5678, 1'b0);
    txn(1, 1'b0, 32'h0000_0007, 32'd0, 32'h1234_5678, 1'b0);
    chk("rdata_hold_after_write", rd[1], 32'h1234_5678);
    txn(1, 1'b1, 32'h0000_0004, 32'h0BAD_F00D, 32'd0, 1'b0);
    chk("rdata_unchanged_by_write", rd[1], 32'h1234_5678);

    // W=0 latency and back-to-back period of 3.
    txn(0, 1'b1, 32'h100, 32'hCAFE_F00D, 32'd0, 1'b0);
    txn(0, 1'b0, 32'h100, 32'd0, 32'hCAFE_F00D, 1'b1);
    txn(0, 1'b0, 32'h100, 32'd0, 32'hCAFE_F00D, 1'b1);
    req[0] = 1'b0;

    // W=2 held request: two writes then two reads, period 5.
    txn(2, 1'b1, 32'h40, 32'hA1A1_0001, 32'd0, 1'b1);
    txn(2, 1'b1, 32'h44, 32'hB2B2_0002, 32'd0, 1'b1);
    txn(2, 1'b0, 32'h40, 32'd0, 32'hA1A1_0001, 1'b1);
    txn(2, 1'b0, 32'h44, 32'd0, 32'hB2B2_0002, 1'b1);
    req[2] = 1'b0;

    // W=3: preload word 8, then abandon an overwrite with reset in its second WAIT cycle.
    txn(3, 1'b1, 32'h20, 32'h5555_5555, 32'd0, 1'b0);
    acc = last_ready[3] + 2;
    req[3] = 1'b1; rw[3] = 1'b1; addr[3] = 32'h20; wd[3] = 32'hAAAA_AAAA;
    while (cyc < acc) begin
      @(negedge clk); #1;
    end
    @(negedge clk); #1;
    rst_n[3] = 1'b0;
    req[3]   = 1'b0;
    @(negedge clk); #1;
    chk("midrst_busy", {31'd0, bsy[3]}, 32'd0);
    repeat (5) begin
      @(negedge clk); #1;
    end
    rst_n[3] = 1'b1;
    txn(3, 1'b0, 32'h20, 32'd0, 32'h5555_5555, 1'b0);

    repeat (8) begin
      @(negedge clk); #1;
    end
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_ram_responder.md
# bus_ram_responder

Bus target that answers the data-side memory bus driven by the CPU data-cache/write-back path. Accepts one read or write transaction at a time on the request/ready handshake and services it from an internal word-wide RAM after a programmable number of wait states. Used as the on-chip scratch/data RAM and as the bench target for exercising CPU bus initiators.

## Interface
- `ADDR_BITS`, 12: word-address width; RAM depth is 2^ADDR_BITS 32-bit words.
- `WAIT_STATES`, 1: extra cycles inserted before the RAM access, 0..15.

- `i_clock`  in  1  sole clock; all state updates on rising edge.
- `i_reset`  in  1  synchronous, active-low reset.
- `i_request`  in  1  initiator requests a transaction; held high until `o_ready` is seen.
- `i_rw`  in  1  0 = read, 1 = write; stable while `i_request` is high.
- `i_address`  in  32  byte address; bits [1:0] ignored, bits [ADDR_BITS+1:2] select the word, upper bits ignored (aliasing).
- `i_wdata`  in  32  write data; stable while `i_request` is high.
- `o_ready`  out  1  one-cycle completion pulse.
- `o_rdata`  out  32  read data, valid while `o_ready` is high after a read.
- `o_busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, WAIT, ACCESS, READY.
- IDLE: if `i_request`=1, latch `i_rw`, word address and `i_wdata`, and load wait counter with WAIT_STATES. Go to WAIT if WAIT_STATES>0, else ACCESS. If `i_request`=0, stay.
- WAIT: decrement counter each cycle; when counter reaches 1 (the last wait cycle), go to ACCESS. The counter is 4 bits wide.
- ACCESS: a write stores the latched data at the latched word address. A read registers RAM[latched address] into `o_rdata`. Go to READY.
- READY: `o_ready`=1 for exactly this cycle. `i_request` is ignored. Next state is IDLE unconditionally.
- Inputs are sampled only in IDLE. Changes to `i_address`/`i_wdata`/`i_rw` after acceptance have no effect.
- If `i_request` drops after acceptance, the transaction still completes: the write is committed and `o_ready` still pulses.
- `o_rdata` holds the last read value. Writes do not change it.
- Read after write to the same word returns the new data, because the write commits in its ACCESS cycle before the next acceptance.
- RAM contents are not initialised and are unaffected by reset.

## Timing
- Reset (`i_reset`=0 at a rising edge): state goes to IDLE. `o_ready`=0, `o_busy`=0, `o_rdata`=0, counter=0, latched fields=0.
  - Reset has priority over everything.
  - A transaction in WAIT or ACCESS is abandoned. A write whose ACCESS cycle coincides with the reset edge is not committed.
- Request sampled high in IDLE in cycle T:
  - WAIT occupies T+1..T+W.
  - ACCESS is cycle T+1+W.
  - `o_ready`=1 in cycle T+2+W, where W=WAIT_STATES.
- Earliest next acceptance is cycle T+3+W. Minimum transaction period is 3+W cycles.
- An initiator holding `i_request` high continuously gets back-to-back transactions at that period. Each `o_ready` pulse completes exactly one transaction.
- `o_busy` is high from T+1 through T+2+W.
- `o_ready` and `o_rdata` are registered outputs with no combinational path from inputs.

## Test plan
- Reset: hold `i_reset`=0 for 3 cycles with `i_request`=1. Required: `o_ready`=0, `o_busy`=0, `o_rdata`=0 throughout. First acceptance happens in the first IDLE cycle after release.
- Write/read, W=1: write 0xDEADBEEF at 0x0000_0010, then read 0x0000_0010. Required: `o_ready` pulses at T+3 for each transaction, and the read returns 0xDEADBEEF.
- Latency, W=0: a read accepted at cycle T. Required: `o_ready` in cycle T+2 only; `o_busy` high in T+1..T+2; next acceptance at T+3.
- Back-to-back, W=2: `i_request` held high for 4 transactions (two writes, then two reads of the same words). Required: exactly 4 `o_ready` pulses, spaced 5 cycles apart, and the reads return the written values.
- Aliasing, ADDR_BITS=12: write 0x1234_5678 to 0x0000_4004, then read 0x0000_0004 and 0x0000_0007. Required: both reads return 0x1234_5678.
- Reset mid-operation, W=3: write 0xAAAA_AAAA to word 8 (pre-loaded with 0x5555_5555), and assert reset in the second WAIT cycle. Required: no `o_ready`, and a later read of word 8 returns 0x5555_5555.
